// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the host/debug port, the arbiter and
// the synchronous data RAM.
//   cpu_*    : CPU MEM-stage request, write data, read data and stall
//   host_*   : host request (held until host_ack), read data and ack pulse
//   d_*      : memory address, write enable, write data and read data
// Modports:
//   slave  : the arbiter's view (consumes requests and d_datain)
//   master : the environment's view (CPU, host and RAM together)
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          host_ack;

  logic [AW-1:0] d_addr;
  logic          d_we;
  logic [DW-1:0] d_dataout;
  logic [DW-1:0] d_datain;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_ack,
    output d_addr, d_we, d_dataout,
    input  d_datain
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_ack,
    input  d_addr, d_we, d_dataout,
    output d_datain
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one synchronous RAM between the CPU MEM stage
// (fixed priority) and a host/debug port. A saturating wait counter forces a
// host grant after MAX_WAIT lost cycles so the host cannot starve.
// Ports:
//   clock : single clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : dmem_arbiter_if.slave carrying CPU, host and memory signals
// The cycle after a host grant is the host's ack cycle: the RAM returns the
// host read data and the host is not eligible, so a still-high host_req
// cannot start a second transaction.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);
  localparam int WCW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_HOST = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [WCW-1:0] wcnt;
  logic          host_gnt;
  logic          cpu_gnt;
  logic          host_rd_p1;
  logic [DW-1:0] host_rdata_q;
  logic          host_ack_int;

  // Grant decision and next owner; everything is gated off during reset.
  always_comb begin
    host_gnt  = 1'b0;
    cpu_gnt   = 1'b0;
    state_nxt = S_IDLE;
    if (!reset) begin
      host_gnt = bus.host_req && (state != S_HOST) &&
                 (!bus.cpu_req || (wcnt >= WCW'(MAX_WAIT)));
      cpu_gnt  = bus.cpu_req && !host_gnt;
    end
    if (host_gnt)
      state_nxt = S_HOST;
    else if (cpu_gnt)
      state_nxt = S_CPU;
  end

  // Memory-side mux of the winner; idle bus is all zero.
  always_comb begin
    bus.d_addr    = '0;
    bus.d_we      = 1'b0;
    bus.d_dataout = '0;
    if (host_gnt) begin
      bus.d_addr    = bus.host_addr;
      bus.d_we      = bus.host_we;
      bus.d_dataout = bus.host_wdata;
    end else if (cpu_gnt) begin
      bus.d_addr    = bus.cpu_addr;
      bus.d_we      = bus.cpu_we;
      bus.d_dataout = bus.cpu_wdata;
    end
  end

  assign host_ack_int  = (state == S_HOST) && !reset;
  assign bus.host_ack  = host_ack_int;
  assign bus.cpu_stall = bus.cpu_req && !cpu_gnt && !reset;
  assign bus.cpu_rdata = bus.d_datain;
  // Read data is presented in the ack cycle straight from the RAM, then held.
  assign bus.host_rdata = (host_ack_int && host_rd_p1) ? bus.d_datain : host_rdata_q;

  // Owner register, read-type flag of the host access, and held host data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      host_rd_p1   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state      <= state_nxt;
      host_rd_p1 <= host_gnt && !bus.host_we;
      if (host_ack_int && host_rd_p1)
        host_rdata_q <= bus.d_datain;
    end
  end

  // Host starvation counter: counts lost cycles, saturates, clears on grant
  // or when the host is not requesting. Holds during the ack cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt <= '0;
    end else if (!bus.host_req || host_gnt) begin
      wcnt <= '0;
    end else if ((state != S_HOST) && (wcnt < WCW'(MAX_WAIT))) begin
      wcnt <= wcnt + 1'b1;
    end
  end
endmodule
